// File: rtl/apb_spi_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_spi_tx_fifo                                               |
// | Purpose  : APB3 slave buffering bytes in a TX FIFO and dispatching them  |
// |            to a write-only SPI shifter over a start/busy handshake.      |
// |            Define APB_SPI_TX_FIFO_IRQ_EN to add the level-threshold irq. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module apb_spi_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int GAP   = 0
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  output logic        spi_msb,
`ifdef APB_SPI_TX_FIFO_IRQ_EN
  output logic        irq,
`endif
  input  logic        spi_busy
);

  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = AW - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_GAPW = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] ACK_LAST = 2'd3;
  localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] level;
  logic [8:0]    level9;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    head;
  logic          ctrl_msb;
  logic          ovf;
  logic [7:0]    data_q;
  logic          msb_q;
  logic [1:0]    ack_cnt;
  logic [7:0]    gap_cnt;
  logic          irq_en_q;
  logic [3:0]    thr_q;

  logic acc_wr;
  logic ctrl_wr;
  logic data_wr;
  logic flush;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic ovf_set;
  logic unused_bits;

  assign acc_wr  = psel & penable & pwrite;
  assign ctrl_wr = acc_wr & (paddr[3:2] == A_CTRL);
  assign data_wr = acc_wr & (paddr[3:2] == A_DATA);
  assign flush   = ctrl_wr & pwdata[5];

  assign level  = wr_ptr - rd_ptr;
  assign level9 = 9'(level);
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1] != rd_ptr[AW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign head   = mem[rd_ptr[IW-1:0]];

  // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
  assign pop     = (state == S_IDLE) & ~empty;
  assign push    = data_wr & ~flush & (~full | pop);
  assign ovf_set = data_wr & ~flush & full & ~pop;

  assign pready      = psel & penable;
  assign pslverr     = 1'b0;
  assign unused_bits = ^{paddr, pwdata};

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= pwdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_msb <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_msb <= pwdata[0];
      if (ctrl_wr && pwdata[4]) ovf <= 1'b0;
      else if (ovf_set)         ovf <= 1'b1;
    end
  end

  // Byte and bit order are frozen at dispatch and held until the next start.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= 8'd0;
      msb_q  <= 1'b0;
    end else if (pop) begin
      data_q <= head;
      msb_q  <= ctrl_msb;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ack_cnt <= 2'd0;
      gap_cnt <= 8'd0;
    end else begin
      ack_cnt <= (state == S_ACK)  ? ack_cnt + 2'd1 : 2'd0;
      gap_cnt <= (state == S_GAPW) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (!empty) state_nx = S_ACK;
      S_ACK:  if (spi_busy || ack_cnt == ACK_LAST) state_nx = S_RUN;
      S_RUN:  if (!spi_busy) state_nx = (GAP == 0) ? S_IDLE : S_GAPW;
      S_GAPW: if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The start pulse carries the head byte directly so it can issue the cycle after busy falls.
  always_comb begin
    spi_start = pop;
    spi_data  = pop ? head : data_q;
    spi_msb   = pop ? ctrl_msb : msb_q;
  end

`ifdef APB_SPI_TX_FIFO_IRQ_EN
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      irq_en_q <= 1'b0;
      thr_q    <= 4'd0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en_q <= pwdata[8];
        thr_q    <= pwdata[15:12];
      end
      irq <= irq_en_q & (level9 <= 9'(thr_q)) & ((state == S_IDLE) | (level != '0) | ovf);
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign thr_q    = 4'd0;
`endif

  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite && paddr[3:2] == A_CTRL) begin
      prdata[0]     = ctrl_msb;
      prdata[1]     = (state != S_IDLE) | ~empty;
      prdata[2]     = full;
      prdata[3]     = empty;
      prdata[4]     = ovf;
      prdata[8]     = irq_en_q;
      prdata[15:12] = thr_q;
      prdata[24:16] = level9;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_spi_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apb_spi_tx_fifo                                            |
// | Purpose  : Self-checking bench for apb_spi_tx_fifo with a shifter model  |
// |            and a queue-based reference (irq part under                   |
// |            APB_SPI_TX_FIFO_IRQ_EN).                                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_apb_spi_tx_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        spi_start;
  logic [7:0]  spi_data;
  logic        spi_msb;
  logic        spi_busy;
`ifdef APB_SPI_TX_FIFO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Shifter model: busy rises the cycle after a start and lasts sh_len cycles.
  bit sh_hold = 1'b0;
  int sh_len = 16;
  int busy_left = 0;

  // Reference: bytes accepted but not yet dispatched, plus register shadows.
  logic [7:0] mq[$];
  bit m_msb = 1'b0;
  bit m_ovf = 1'b0;
  bit m_irq_en = 1'b0;
  logic [3:0] m_thr = 4'd0;

  int n_starts = 0;
  int last_fall = -100;
  int start_gap = -1;
  bit busy_d = 1'b0;

  apb_spi_tx_fifo #(.DEPTH(DEPTH), .GAP(0)) dut (
    .clk(clk), .rst_i(rst_i), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .spi_start(spi_start), .spi_data(spi_data), .spi_msb(spi_msb),
`ifdef APB_SPI_TX_FIFO_IRQ_EN
    .irq(irq),
`endif
    .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign spi_busy = sh_hold | (busy_left != 0);
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i)                busy_left <= 0;
    else if (spi_start)        busy_left <= sh_len;
    else if (busy_left != 0)   busy_left <= busy_left - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Every dispatched byte must be the oldest accepted byte, sent with the current bit order.
  initial begin
    forever begin
      @(negedge clk);
      if (busy_d && !spi_busy) last_fall = cyc;
      busy_d = spi_busy;
      if (rst_i && spi_start) begin
        n_starts++;
        start_gap = cyc - last_fall;
        if (mq.size() == 0) fail_timeout("unexpected_start");
        else begin
          check("start_data", {24'd0, spi_data}, {24'd0, mq[0]});
          check("start_msb", {31'd0, spi_msb}, {31'd0, m_msb});
          void'(mq.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] stat_exp(input bit inflight);
    logic [31:0] s;
    s = 32'd0;
    s[0] = m_msb;
    s[1] = inflight | (mq.size() != 0);
    s[2] = (mq.size() == DEPTH);
    s[3] = (mq.size() == 0);
    s[4] = m_ovf;
`ifdef APB_SPI_TX_FIFO_IRQ_EN
    s[8] = m_irq_en;
    s[15:12] = m_thr;
`endif
    s[24:16] = 9'(mq.size());
    return s;
  endfunction

  function automatic void model_wr(input logic [7:0] a, input logic [31:0] d);
    if (a[3:2] == 2'd1) begin
      if (mq.size() < DEPTH) mq.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end else if (a[3:2] == 2'd0) begin
      m_msb = d[0];
      m_irq_en = d[8];
      m_thr = d[15:12];
      if (d[4]) m_ovf = 1'b0;
      if (d[5]) mq.delete();
    end
  endfunction

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 check("pready_wr", {31'd0, pready}, 32'd1);
    check("pslverr_wr", {31'd0, pslverr}, 32'd0);
    @(posedge clk);
    model_wr(a, d);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata;
    check("pready_rd", {31'd0, pready}, 32'd1);
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int quiet = 0;
    for (int i = 0; i < 4000 && quiet < 3; i++) begin
      @(negedge clk); #1;
      if (mq.size() == 0 && !spi_busy) quiet++; else quiet = 0;
    end
    if (quiet < 3) fail_timeout(tag);
  endtask

  task automatic wait_start(input int n0, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #1;
      if (n_starts > n0) seen = 1'b1;
    end
    if (!seen) fail_timeout(tag);
  endtask

  initial begin
    logic [31:0] d;
    int n0;
    int n1;
    int cnt;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_start", {31'd0, spi_start}, 32'd0);
    check("rst_data", {24'd0, spi_data}, 32'd0);
    check("rst_msb", {31'd0, spi_msb}, 32'd0);
`ifdef APB_SPI_TX_FIFO_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    rst_i = 1'b1;
    apb_rd(8'h00, d);
    check("rst_stat", d, 32'h0000_0008);

    // Asynchronous reset mid-transfer: one byte running, five queued
    apb_wr(8'h00, 32'h1);
    sh_hold = 1'b1;
    for (int k = 0; k < 6; k++) apb_wr(8'h04, 32'hF0 + k);
    repeat (4) @(negedge clk);
    apb_rd(8'h00, d);
    check("pre_rst_stat", d, stat_exp(1'b1));
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_start", {31'd0, spi_start}, 32'd0);
    check("async_rst_data", {24'd0, spi_data}, 32'd0);
    check("async_rst_msb", {31'd0, spi_msb}, 32'd0);
    check("async_rst_prdata", prdata, 32'd0);
    mq.delete(); m_msb = 1'b0; m_ovf = 1'b0; sh_hold = 1'b0;
    @(negedge clk); rst_i = 1'b1;
    apb_rd(8'h00, d);
    check("post_rst_stat", d, 32'h0000_0008);

    // Two bytes MSB-first; back-to-back restart one cycle after busy falls
    sh_len = 16;
    n0 = n_starts;
    apb_wr(8'h00, 32'h1);
    apb_wr(8'h04, 32'hA5);
    apb_wr(8'h04, 32'h3C);
    wait_drain("two_byte_drain");
    check("two_starts", n_starts - n0, 32'd2);
    check("restart_gap", start_gap, 32'd1);

    // Overflow with the shifter stuck busy and one byte already in flight
    sh_hold = 1'b1;
    n0 = n_starts;
    apb_wr(8'h04, $urandom);
    wait_start(n0, "ovf_first_start");
    repeat (2) @(negedge clk);
    for (int k = 0; k < 17; k++) apb_wr(8'h04, $urandom);
    apb_rd(8'h00, d);
    check("ovf_stat", d, stat_exp(1'b1));
    check("ovf_stat_lit", d, 32'h0010_0017);
    apb_wr(8'h00, 32'h11);
    apb_rd(8'h00, d);
    check("ovf_clear_stat", d, 32'h0010_0007);

    // Full FIFO: a DATA write landing on the pop cycle is accepted
    @(negedge clk);
    sh_hold = 1'b0;
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h5A; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 check("coincide_start", {31'd0, spi_start}, 32'd1);
    @(posedge clk);
    model_wr(8'h04, 32'h5A);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_rd(8'h00, d);
    check("coincide_stat", d, stat_exp(1'b1));
    check("coincide_stat_lit", d, 32'h0010_0007);
    wait_drain("coincide_drain");

    // Flush with three bytes queued behind one in flight
    n0 = n_starts;
    for (int k = 0; k < 4; k++) apb_wr(8'h04, $urandom);
    apb_wr(8'h00, 32'h21);
    apb_rd(8'h00, d);
    check("flush_stat", d, stat_exp(1'b1));
    n1 = n_starts;
    wait_drain("flush_drain");
    check("flush_no_more_starts", n_starts, n1);
    check("flush_one_sent", n_starts - n0, 32'd1);
    apb_rd(8'h00, d);
    check("flush_idle_stat", d, 32'h0000_0009);

    // Reserved and DATA reads return zero; reserved writes do nothing
    apb_wr(8'h08, $urandom);
    apb_wr(8'h0C, $urandom);
    apb_rd(8'h08, d); check("rsvd2_rd", d, 32'd0);
    apb_rd(8'h0C, d); check("rsvd3_rd", d, 32'd0);
    apb_rd(8'h04, d); check("data_rd", d, 32'd0);
    apb_rd(8'h00, d); check("rsvd_no_push", d, stat_exp(1'b0));

    // Randomized rounds: random bit order, shifter length, burst size and spacing
    for (int r = 0; r < 6; r++) begin
      sh_len = $urandom_range(1, 24);
      apb_wr(8'h00, 32'h10 | 32'($urandom_range(0, 1)));
      cnt = $urandom_range(1, 24);
      for (int k = 0; k < cnt; k++) begin
        apb_wr(8'($urandom_range(0, 15) << 4) | 8'h04, $urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain("round_drain");
      apb_rd(8'h00, d);
      check("round_stat", d, stat_exp(1'b0));
    end

`ifdef APB_SPI_TX_FIFO_IRQ_EN
    // Level-threshold irq: thr=2, five bytes queued behind one in flight
    sh_len = 16;
    apb_wr(8'h00, 32'h0000_2101);
    sh_hold = 1'b1;
    for (int k = 0; k < 6; k++) apb_wr(8'h04, $urandom);
    repeat (3) @(negedge clk);
    check("irq_low_lvl5", {31'd0, irq}, 32'd0);
    sh_hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk); #1;
      if (mq.size() == 2) found = 1'b1;
    end
    if (!found) fail_timeout("irq_level2");
    @(negedge clk);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_high_lvl2", {31'd0, irq}, 32'd1);
    apb_wr(8'h00, 32'h0000_2001);
    @(negedge clk);
    check("irq_hold_one", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_dropped", {31'd0, irq}, 32'd0);
    wait_drain("irq_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
